// File: rtl/ps2_kbd_ctrl.sv
// PS/2 keyboard host controller: reset/self-test handshake, LED command with
// resend handling, and forwarding of decoded key events while idle.
module ps2_kbd_ctrl #(
    parameter int INHIBIT_CYCLES = 10000,
    parameter int TIMEOUT_CYCLES = 2000000,
    parameter int MAX_RETRY      = 3
) (
    input  logic       clk,
    input  logic       reset_n,
    input  logic       ps2_clk,
    input  logic       ps2_data,
    output logic       ps2_clk_oe,
    output logic       ps2_data_oe,
    input  logic [9:0] rx_data,
    input  logic       rx_ready,
    input  logic       led_req,
    input  logic [2:0] led_val,
    output logic       key_valid,
    output logic [9:0] key_data,
    output logic       busy,
    output logic       init_done,
    output logic       error
);
    localparam int CNT_MAX = (TIMEOUT_CYCLES > INHIBIT_CYCLES) ? TIMEOUT_CYCLES : INHIBIT_CYCLES;
    localparam int CNT_W   = $clog2(CNT_MAX + 1);
    localparam int RTY_W   = $clog2(MAX_RETRY + 1) + 1;

    typedef enum logic [2:0] {
        S_INIT, S_IDLE, S_INHIBIT, S_START, S_TX, S_ACK, S_RESP, S_ERR
    } state_t;

    // Which byte of which command is outstanding, and hence which reply is expected.
    typedef enum logic [1:0] {
        P_INIT_FA, P_INIT_AA, P_LED_CMD, P_LED_VAL
    } step_t;

    state_t           state, state_nx;
    step_t            step;
    logic [1:0]       clk_sync, data_sync;
    logic             clk_prev;
    logic             ps2_fall, data_s;
    logic [CNT_W-1:0] cnt;
    logic [3:0]       edge_cnt;
    logic [RTY_W-1:0] retry_cnt;
    logic [7:0]       tx_byte;
    logic [7:0]       rsp_code, rsp_expect;
    logic [2:0]       led_lat;
    logic [8:0]       tx_frame;
    logic             tx_bit;
    logic             inh_done, to_hit, timed_state;
    logic             rsp_ok, rsp_resend, retry_left;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            clk_sync  <= 2'b11;
            data_sync <= 2'b11;
            clk_prev  <= 1'b1;
        end else begin
            clk_sync  <= {clk_sync[0], ps2_clk};
            data_sync <= {data_sync[0], ps2_data};
            clk_prev  <= clk_sync[1];
        end
    end

    assign ps2_fall    = clk_prev & ~clk_sync[1];
    assign data_s      = data_sync[1];
    assign rsp_code    = rx_data[7:0];
    assign rsp_expect  = (step == P_INIT_AA) ? 8'hAA : 8'hFA;
    assign rsp_ok      = (state == S_RESP) && rx_ready && (rsp_code == rsp_expect);
    assign rsp_resend  = (state == S_RESP) && rx_ready && (rsp_code == 8'hFE);
    assign retry_left  = (retry_cnt != RTY_W'(MAX_RETRY));
    assign inh_done    = (cnt == CNT_W'(INHIBIT_CYCLES - 1));
    assign to_hit      = (cnt == CNT_W'(TIMEOUT_CYCLES - 1));
    assign timed_state = (state == S_START) || (state == S_TX) || (state == S_ACK) || (state == S_RESP);

    // Frame bit n (1..9) is shifted out after the n-th device clock fall; bit 9 is odd parity.
    assign tx_frame = {~^tx_byte, tx_byte};
    assign tx_bit   = (edge_cnt >= 4'd1 && edge_cnt <= 4'd9) ? tx_frame[edge_cnt - 4'd1] : 1'b1;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) state <= S_INIT;
        else          state <= state_nx;
    end

    always_comb begin
        state_nx = state;
        case (state)
            S_INIT:    state_nx = S_INHIBIT;
            S_IDLE:    if (led_req) state_nx = S_INHIBIT;
            S_INHIBIT: if (inh_done) state_nx = S_START;
            S_START: begin
                if (ps2_fall)    state_nx = S_TX;
                else if (to_hit) state_nx = S_ERR;
            end
            S_TX: begin
                if (ps2_fall) begin
                    if (edge_cnt == 4'd9) state_nx = S_ACK;
                end else if (to_hit) begin
                    state_nx = S_ERR;
                end
            end
            S_ACK: begin
                if (ps2_fall)    state_nx = data_s ? S_ERR : S_RESP;
                else if (to_hit) state_nx = S_ERR;
            end
            S_RESP: begin
                if (rsp_ok) begin
                    case (step)
                        P_INIT_FA: state_nx = S_RESP;
                        P_LED_CMD: state_nx = S_INHIBIT;
                        default:   state_nx = S_IDLE;
                    endcase
                end else if (rsp_resend) begin
                    state_nx = retry_left ? S_INHIBIT : S_ERR;
                end else if (to_hit) begin
                    state_nx = S_ERR;
                end
            end
            S_ERR:   state_nx = S_IDLE;
            default: state_nx = S_INIT;
        endcase
    end

    always_comb begin
        ps2_clk_oe  = 1'b0;
        ps2_data_oe = 1'b0;
        case (state)
            S_INHIBIT: ps2_clk_oe  = 1'b1;
            S_START:   ps2_data_oe = 1'b1;
            S_TX:      ps2_data_oe = ~tx_bit;
            default:   ;
        endcase
    end

    // A reply that advances within RESP counts as a fresh wait for the timeout.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            cnt <= '0;
        end else if ((state_nx != state) || rsp_ok || (timed_state && ps2_fall)) begin
            cnt <= '0;
        end else if (cnt != CNT_W'(CNT_MAX)) begin
            cnt <= cnt + CNT_W'(1);
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            edge_cnt <= '0;
        end else if (state == S_INHIBIT) begin
            edge_cnt <= '0;
        end else if (state == S_START && ps2_fall) begin
            edge_cnt <= 4'd1;
        end else if (state == S_TX && ps2_fall) begin
            edge_cnt <= edge_cnt + 4'd1;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            tx_byte   <= '0;
            step      <= P_INIT_FA;
            retry_cnt <= '0;
            led_lat   <= '0;
        end else if (state == S_INIT) begin
            tx_byte   <= 8'hFF;
            step      <= P_INIT_FA;
            retry_cnt <= '0;
        end else if (state == S_IDLE && led_req) begin
            led_lat   <= led_val;
            tx_byte   <= 8'hED;
            step      <= P_LED_CMD;
            retry_cnt <= '0;
        end else if (rsp_ok) begin
            case (step)
                P_INIT_FA: step <= P_INIT_AA;
                P_LED_CMD: begin
                    step      <= P_LED_VAL;
                    tx_byte   <= {5'b0, led_lat};
                    retry_cnt <= '0;
                end
                default: ;
            endcase
        end else if (rsp_resend && retry_left) begin
            retry_cnt <= retry_cnt + RTY_W'(1);
            // A resend during self-test wait means 0xFF goes again, so 0xFA is owed first.
            if (step == P_INIT_AA) step <= P_INIT_FA;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            busy      <= 1'b0;
            error     <= 1'b0;
            init_done <= 1'b0;
            key_valid <= 1'b0;
            key_data  <= '0;
        end else begin
            busy      <= (state_nx != S_IDLE);
            key_valid <= (state == S_IDLE) && rx_ready;
            if (state == S_IDLE && rx_ready) key_data <= rx_data;
            if (state_nx == S_ERR) error <= 1'b1;
            if (rsp_ok && step == P_INIT_AA) init_done <= 1'b1;
        end
    end

endmodule

// File: tb/tb_ps2_kbd_ctrl.sv
// Directed bench for ps2_kbd_ctrl with a simple open-drain PS/2 device model.
module tb_ps2_kbd_ctrl;
    localparam int INH = 20;
    localparam int TO  = 500;
    localparam int MR  = 3;
    localparam int HP  = 10;

    logic       clk = 1'b0;
    logic       reset_n = 1'b0;
    logic       dev_clk = 1'b1;
    logic       dev_data = 1'b1;
    logic       ps2_clk_oe, ps2_data_oe;
    logic [9:0] rx_data = '0;
    logic       rx_ready = 1'b0;
    logic       led_req = 1'b0;
    logic [2:0] led_val = '0;
    logic       key_valid;
    logic [9:0] key_data;
    logic       busy, init_done, error;
    logic       ps2_clk_line, ps2_data_line;

    int n_tests = 0;
    int n_fail  = 0;

    logic [7:0] b;
    logic       p;

    typedef struct {
        logic       rdy;
        logic [9:0] din;
        logic       exp_v;
        logic [9:0] exp_d;
    } kvec_t;
    kvec_t kv[6];

    assign ps2_clk_line  = dev_clk  & ~ps2_clk_oe;
    assign ps2_data_line = dev_data & ~ps2_data_oe;

    ps2_kbd_ctrl #(
        .INHIBIT_CYCLES(INH),
        .TIMEOUT_CYCLES(TO),
        .MAX_RETRY(MR)
    ) dut (
        .clk(clk),
        .reset_n(reset_n),
        .ps2_clk(ps2_clk_line),
        .ps2_data(ps2_data_line),
        .ps2_clk_oe(ps2_clk_oe),
        .ps2_data_oe(ps2_data_oe),
        .rx_data(rx_data),
        .rx_ready(rx_ready),
        .led_req(led_req),
        .led_val(led_val),
        .key_valid(key_valid),
        .key_data(key_data),
        .busy(busy),
        .init_done(init_done),
        .error(error)
    );

    always #5 clk = ~clk;

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic cyc(input int n);
        repeat (n) @(negedge clk);
    endtask

    // Wait for the host request, time the inhibit, then clock one frame in as the device.
    task automatic host_frame(input string tag, output logic [7:0] byt, output logic par);
        int t;
        int len;
        byt = '0;
        par = 1'b0;
        t = 0;
        while (ps2_clk_oe !== 1'b1 && t < 3000) begin
            @(negedge clk);
            t++;
        end
        check({tag, " inhibit seen"}, ps2_clk_oe, 1);
        if (ps2_clk_oe !== 1'b1) return;
        len = 0;
        while (ps2_clk_oe === 1'b1 && len < INH + 50) begin
            @(negedge clk);
            len++;
        end
        check({tag, " inhibit len"}, len, INH);
        check({tag, " start bit"}, ps2_data_oe, 1);
        cyc(3);
        for (int i = 1; i <= 10; i++) begin
            dev_clk = 1'b0;
            cyc(HP);
            dev_clk = 1'b1;
            if (i <= 8)      byt[i-1] = ps2_data_line;
            else if (i == 9) par = ps2_data_line;
            else             check({tag, " stop released"}, ps2_data_line, 1);
            cyc(HP);
        end
        dev_data = 1'b0;
        dev_clk  = 1'b0;
        cyc(HP);
        dev_clk  = 1'b1;
        dev_data = 1'b1;
        cyc(HP);
    endtask

    task automatic respond(input logic [7:0] code);
        rx_data  = {2'b00, code};
        rx_ready = 1'b1;
        @(negedge clk);
        rx_ready = 1'b0;
    endtask

    task automatic do_init(input string tag);
        logic [7:0] ib;
        logic       ip;
        host_frame(tag, ib, ip);
        check({tag, " byte"}, ib, 8'hFF);
        check({tag, " parity"}, ip, 1);
        check({tag, " busy"}, busy, 1);
        respond(8'hFA);
        check({tag, " init_done before AA"}, init_done, 0);
        respond(8'hAA);
        cyc(1);
        check({tag, " init_done"}, init_done, 1);
        check({tag, " idle busy"}, busy, 0);
    endtask

    initial begin
        int t;
        int n;
        kv[0] = '{1'b1, 10'h01C, 1'b1, 10'h01C};
        kv[1] = '{1'b0, 10'h155, 1'b0, 10'h01C};
        kv[2] = '{1'b1, 10'h2F0, 1'b1, 10'h2F0};
        kv[3] = '{1'b1, 10'h1AA, 1'b1, 10'h1AA};
        kv[4] = '{1'b1, 10'h3FF, 1'b1, 10'h3FF};
        kv[5] = '{1'b0, 10'h000, 1'b0, 10'h3FF};

        // Reset state
        cyc(3);
        check("rst clk_oe", ps2_clk_oe, 0);
        check("rst data_oe", ps2_data_oe, 0);
        check("rst busy", busy, 0);
        check("rst init_done", init_done, 0);
        check("rst error", error, 0);
        check("rst key_valid", key_valid, 0);
        check("rst key_data", key_data, 0);
        reset_n = 1'b1;

        do_init("init");
        check("init error", error, 0);

        // Key forwarding in IDLE
        for (int i = 0; i < 6; i++) begin
            rx_ready = kv[i].rdy;
            rx_data  = kv[i].din;
            @(negedge clk);
            check($sformatf("key%0d valid", i), key_valid, kv[i].exp_v);
            check($sformatf("key%0d data", i), key_data, kv[i].exp_d);
        end
        rx_ready = 1'b0;
        cyc(2);

        // LED command 3'b101, with key suppression and dropped request while busy
        led_val = 3'b101;
        led_req = 1'b1;
        @(negedge clk);
        led_req = 1'b0;
        check("led busy", busy, 1);
        host_frame("led cmd", b, p);
        check("led cmd byte", b, 8'hED);
        check("led cmd parity", p, 1);
        rx_data  = 10'h01C;
        rx_ready = 1'b1;
        @(negedge clk);
        rx_ready = 1'b0;
        check("resp key suppressed", key_valid, 0);
        led_val = 3'b010;
        led_req = 1'b1;
        @(negedge clk);
        led_req = 1'b0;
        check("resp still busy", busy, 1);
        respond(8'hFA);
        host_frame("led val", b, p);
        check("led val byte", b, 8'h05);
        check("led val parity", p, 1);
        check("led val busy", busy, 1);
        respond(8'hFA);
        check("led done busy", busy, 0);
        cyc(INH + 10);
        check("dropped req busy", busy, 0);
        check("dropped req clk_oe", ps2_clk_oe, 0);

        // Coincident key event and LED request, then two resends
        rx_data  = 10'h012;
        rx_ready = 1'b1;
        led_val  = 3'b010;
        led_req  = 1'b1;
        @(negedge clk);
        rx_ready = 1'b0;
        led_req  = 1'b0;
        check("coinc key_valid", key_valid, 1);
        check("coinc key_data", key_data, 10'h012);
        check("coinc busy", busy, 1);
        for (int k = 0; k < 3; k++) begin
            host_frame($sformatf("retry%0d", k), b, p);
            check($sformatf("retry%0d byte", k), b, 8'hED);
            respond((k < 2) ? 8'hFE : 8'hFA);
        end
        host_frame("retry val", b, p);
        check("retry val byte", b, 8'h02);
        check("retry val parity", p, 0);
        respond(8'hFA);
        check("retry done busy", busy, 0);
        check("retry no error", error, 0);

        // Retries exhausted
        led_val = 3'b111;
        led_req = 1'b1;
        @(negedge clk);
        led_req = 1'b0;
        for (int k = 0; k < 4; k++) begin
            host_frame($sformatf("exh%0d", k), b, p);
            check($sformatf("exh%0d byte", k), b, 8'hED);
            check($sformatf("exh%0d error", k), error, 0);
            respond(8'hFE);
        end
        cyc(2);
        check("exh error", error, 1);
        check("exh busy", busy, 0);
        check("exh clk_oe", ps2_clk_oe, 0);
        check("exh data_oe", ps2_data_oe, 0);

        // Reset clears error; reset mid-transmit releases lines and restarts INIT
        reset_n = 1'b0;
        cyc(2);
        check("rst2 error", error, 0);
        reset_n = 1'b1;
        do_init("init2");
        led_val = 3'b000;
        led_req = 1'b1;
        @(negedge clk);
        led_req = 1'b0;
        t = 0;
        while (!(ps2_clk_oe === 1'b0 && ps2_data_oe === 1'b1) && t < 3000) begin
            @(negedge clk);
            t++;
        end
        check("midtx start", ps2_data_oe, 1);
        cyc(3);
        for (int i = 1; i <= 5; i++) begin
            dev_clk = 1'b0;
            cyc(HP);
            if (i < 5) begin
                dev_clk = 1'b1;
                cyc(HP);
            end
        end
        check("midtx bit4 driven", ps2_data_oe, 1);
        #1 reset_n = 1'b0;
        #1;
        check("midtx rst clk_oe", ps2_clk_oe, 0);
        check("midtx rst data_oe", ps2_data_oe, 0);
        check("midtx rst busy", busy, 0);
        dev_clk = 1'b1;
        @(negedge clk);
        reset_n = 1'b1;
        do_init("reinit");

        // Device never clocks: START timeout
        reset_n = 1'b0;
        cyc(2);
        reset_n = 1'b1;
        t = 0;
        while (ps2_clk_oe !== 1'b1 && t < 3000) begin
            @(negedge clk);
            t++;
        end
        t = 0;
        while (ps2_clk_oe === 1'b1 && t < INH + 50) begin
            @(negedge clk);
            t++;
        end
        check("to start bit", ps2_data_oe, 1);
        n = 0;
        while (error !== 1'b1 && n < TO + 50) begin
            @(negedge clk);
            n++;
        end
        check("to cycles", n, TO);
        check("to clk_oe", ps2_clk_oe, 0);
        check("to data_oe", ps2_data_oe, 0);
        cyc(2);
        check("to busy", busy, 0);
        check("to init_done", init_done, 0);
        check("to error sticky", error, 1);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
